// File: rtl/stripe_frame_controller.sv
// Frame sequencer: walks a frame in stripes, running fetch then core per stripe,
// with optional VGA hand-off, continuous mode, abort and a per-phase watchdog.
module stripe_frame_controller #(
    parameter int IMG_ROW     = 540,
    parameter int STRIPE_ROWS = 8,
    parameter int ROW_W       = 10,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int TO_W        = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_cont_i,
    input  logic             vga_run_i,
    input  logic             fetch_done_i,
    input  logic             core_done_i,
    output logic             fetch_run_o,
    output logic [ROW_W-1:0] fetch_row_o,
    output logic [ROW_W-1:0] fetch_rows_o,
    output logic             core_run_o,
    output logic             vga_en_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_timeout_o,
    output logic [2:0]       state_o,
    output logic [15:0]      frame_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CORE  = 3'd2,
        S_DONE  = 3'd3,
        S_VGA   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // One extra bit so row + STRIPE_ROWS cannot overflow in the end-of-frame test
    localparam logic [ROW_W:0]  IMG_W    = (ROW_W+1)'(IMG_ROW);
    localparam logic [ROW_W:0]  STRIPE_W = (ROW_W+1)'(STRIPE_ROWS);
    localparam bit              WD_ON    = (TIMEOUT_CYC > 0);
    localparam logic [TO_W-1:0] WD_LAST  = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_t           state, state_n;
    logic [ROW_W-1:0] row_n;
    logic [TO_W-1:0]  wd_cnt;
    logic             err_n;
    logic             wd_expire;
    logic             last_stripe;
    logic             enter_fetch;
    logic             enter_core;

    function automatic logic [ROW_W-1:0] stripe_rows(input logic [ROW_W-1:0] r);
        logic [ROW_W:0] rem;
        rem = IMG_W - {1'b0, r};
        if (rem < STRIPE_W)
            return rem[ROW_W-1:0];
        return STRIPE_W[ROW_W-1:0];
    endfunction

    assign wd_expire   = WD_ON && (wd_cnt == WD_LAST);
    assign last_stripe = ({1'b0, fetch_row_o} + STRIPE_W) >= IMG_W;
    assign enter_fetch = (state_n == S_FETCH) && (state != S_FETCH);
    assign enter_core  = (state_n == S_CORE) && (state != S_CORE);
    assign state_o     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        row_n   = fetch_row_o;
        err_n   = err_timeout_o;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_FETCH;
                    row_n   = '0;
                end
            end
            S_FETCH: begin
                if (fetch_done_i) begin
                    state_n = S_CORE;
                end else if (wd_expire) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                end
            end
            S_CORE: begin
                if (core_done_i) begin
                    if (last_stripe) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        row_n   = fetch_row_o + STRIPE_W[ROW_W-1:0];
                    end
                end else if (wd_expire) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                end
            end
            S_DONE: begin
                if (vga_run_i) begin
                    state_n = S_VGA;
                end else if (mode_cont_i) begin
                    state_n = S_FETCH;
                    row_n   = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_VGA: begin
                if (!vga_run_i) begin
                    if (mode_cont_i) begin
                        state_n = S_FETCH;
                        row_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                if (start_i) begin
                    state_n = S_FETCH;
                    row_n   = '0;
                    err_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Abort beats start and any done pulse arriving in the same cycle
        if (abort_i) begin
            state_n = S_IDLE;
            row_n   = '0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_row_o   <= '0;
            fetch_rows_o  <= '0;
            fetch_run_o   <= 1'b0;
            core_run_o    <= 1'b0;
            vga_en_o      <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            err_timeout_o <= 1'b0;
            frame_cnt_o   <= '0;
            wd_cnt        <= '0;
        end else begin
            fetch_row_o   <= row_n;
            fetch_run_o   <= enter_fetch;
            core_run_o    <= enter_core;
            vga_en_o      <= (state_n == S_VGA);
            busy_o        <= (state_n == S_FETCH) || (state_n == S_CORE) ||
                             (state_n == S_DONE)  || (state_n == S_VGA);
            frame_done_o  <= (state_n == S_DONE);
            err_timeout_o <= err_n;
            if (enter_fetch)
                fetch_rows_o <= stripe_rows(row_n);
            if (state_n == S_DONE)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (state_n != state)
                wd_cnt <= '0;
            else if ((state == S_FETCH) || (state == S_CORE))
                wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_stripe_frame_controller.sv
// Bench for stripe_frame_controller: a cycle model of the frame rules checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_stripe_frame_controller;
    localparam int IMG = 20;
    localparam int SR  = 8;
    localparam int RW  = 5;
    localparam int TO  = 16;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0, abort_i = 1'b0, mode_cont_i = 1'b0, vga_run_i = 1'b0;
    logic          fetch_done_i = 1'b0, core_done_i = 1'b0;
    logic          fetch_run_o, core_run_o, vga_en_o, busy_o, frame_done_o, err_timeout_o;
    logic [RW-1:0] fetch_row_o, fetch_rows_o;
    logic [2:0]    state_o;
    logic [15:0]   frame_cnt_o;

    always #5 clk = ~clk;

    stripe_frame_controller #(
        .IMG_ROW(IMG), .STRIPE_ROWS(SR), .ROW_W(RW), .TIMEOUT_CYC(TO), .TO_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .mode_cont_i(mode_cont_i), .vga_run_i(vga_run_i),
        .fetch_done_i(fetch_done_i), .core_done_i(core_done_i),
        .fetch_run_o(fetch_run_o), .fetch_row_o(fetch_row_o), .fetch_rows_o(fetch_rows_o),
        .core_run_o(core_run_o), .vga_en_o(vga_en_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .err_timeout_o(err_timeout_o),
        .state_o(state_o), .frame_cnt_o(frame_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: state number, current stripe row, cycles spent in the current state
    int m_state = 0, m_row = 0, m_age = 0, m_cnt = 0;
    bit m_err = 0;
    int ns, nr;
    bit ne;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_row <= 0; m_age <= 0; m_cnt <= 0; m_err <= 0;
        end else begin
            ns = m_state; nr = m_row; ne = m_err;
            if (abort_i) begin
                ns = 0; nr = 0; ne = 0;
            end else begin
                case (m_state)
                    0: if (start_i) begin ns = 1; nr = 0; end
                    1: if (fetch_done_i) ns = 2;
                       else if (m_age == TO - 1) begin ns = 5; ne = 1; end
                    2: if (core_done_i) begin
                           if (m_row + SR >= IMG) ns = 3;
                           else begin ns = 1; nr = m_row + SR; end
                       end else if (m_age == TO - 1) begin ns = 5; ne = 1; end
                    3: begin
                           ns = vga_run_i ? 4 : (mode_cont_i ? 1 : 0);
                           if (ns == 1) nr = 0;
                       end
                    4: if (!vga_run_i) begin
                           ns = mode_cont_i ? 1 : 0;
                           if (ns == 1) nr = 0;
                       end
                    5: if (start_i) begin ns = 1; nr = 0; ne = 0; end
                    default: ns = 0;
                endcase
            end
            m_age <= (ns == m_state) ? m_age + 1 : 0;
            if (ns == 3) m_cnt <= (m_cnt + 1) % 65536;
            m_state <= ns; m_row <= nr; m_err <= ne;
        end
    end

    int n_fetch = 0, n_core = 0, n_done = 0, n_vga = 0, n_corecyc = 0, n_busy_drop = 0;
    bit busy_win = 0;
    int row_q[$];
    int rows_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", state_o, m_state);
            chk("fetch_run", fetch_run_o, (m_state == 1 && m_age == 0));
            chk("core_run", core_run_o, (m_state == 2 && m_age == 0));
            chk("frame_done", frame_done_o, (m_state == 3));
            chk("vga_en", vga_en_o, (m_state == 4));
            chk("busy", busy_o, (m_state >= 1 && m_state <= 4));
            chk("err_timeout", err_timeout_o, m_err);
            chk("frame_cnt", frame_cnt_o, m_cnt);
            chk("fetch_row", fetch_row_o, m_row);
            if (m_state == 1 || m_state == 2)
                chk("fetch_rows", fetch_rows_o, (IMG - m_row < SR) ? IMG - m_row : SR);
            if (fetch_run_o) begin
                n_fetch++;
                row_q.push_back(int'(fetch_row_o));
                rows_q.push_back(int'(fetch_rows_o));
            end
            if (core_run_o) n_core++;
            if (frame_done_o) n_done++;
            if (vga_en_o) n_vga++;
            if (state_o == 3'd2) n_corecyc++;
            if (busy_win && !busy_o) n_busy_drop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fetch_run(input int max);
        int n = 0;
        while (!fetch_run_o && n < max) begin tick(); n++; end
        chk("wait_fetch_run", fetch_run_o, 1);
    endtask

    task automatic wait_core_run(input int max);
        int n = 0;
        while (!core_run_o && n < max) begin tick(); n++; end
        chk("wait_core_run", core_run_o, 1);
    endtask

    task automatic wait_state(input int s, input int max);
        int n = 0;
        while (int'(state_o) != s && n < max) begin tick(); n++; end
        chk("wait_state", state_o, s);
    endtask

    task automatic serve_fetch(input int d);
        wait_fetch_run(40);
        repeat (d) tick();
        fetch_done_i = 1'b1; tick(); fetch_done_i = 1'b0;
    endtask

    task automatic serve_core(input int d);
        wait_core_run(40);
        repeat (d) tick();
        core_done_i = 1'b1; tick(); core_done_i = 1'b0;
    endtask

    task automatic start_frame();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    task automatic chk_rows(input string name, input int q0);
        chk({name, "_row0"}, row_q[q0], 0);
        chk({name, "_row1"}, row_q[q0+1], 8);
        chk({name, "_row2"}, row_q[q0+2], 16);
        chk({name, "_rows0"}, rows_q[q0], 8);
        chk({name, "_rows1"}, rows_q[q0+1], 8);
        chk({name, "_rows2"}, rows_q[q0+2], 4);
    endtask

    int q0, f0, c0, d0, v0;

    initial begin
        #12;
        chk("rst_state", state_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fetch_row", fetch_row_o, 0);
        chk("rst_fetch_rows", fetch_rows_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_err", err_timeout_o, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (2) tick();

        // Plain frame: three stripes 0/8/16 with 8/8/4 rows
        q0 = row_q.size(); f0 = n_fetch; c0 = n_core; d0 = n_done;
        start_frame();
        repeat (3) begin serve_fetch(2); serve_core(2); end
        wait_state(0, 10);
        chk("t1_fetch_pulses", n_fetch - f0, 3);
        chk("t1_core_pulses", n_core - c0, 3);
        chk("t1_done_pulses", n_done - d0, 1);
        chk("t1_frame_cnt", frame_cnt_o, 1);
        chk_rows("t1", q0);

        // fetch_done in the fetch_run cycle plus a stray core_done in FETCH
        q0 = row_q.size();
        start_frame();
        fetch_done_i = 1'b1; core_done_i = 1'b1;
        tick();
        fetch_done_i = 1'b0; core_done_i = 1'b0;
        chk("t2_core_state", state_o, 2);
        chk("t2_core_run", core_run_o, 1);
        serve_core(2);
        repeat (2) begin serve_fetch(2); serve_core(2); end
        wait_state(0, 10);
        chk("t2_frame_cnt", frame_cnt_o, 2);
        chk_rows("t2", q0);

        // Continuous mode, three back-to-back frames
        mode_cont_i = 1'b1; f0 = n_fetch; q0 = row_q.size();
        start_frame();
        busy_win = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 3; s++) begin
                serve_fetch(2);
                if (f == 2 && s == 2) mode_cont_i = 1'b0;
                serve_core(2);
            end
        end
        busy_win = 1'b0;
        wait_state(0, 10);
        chk("t3_busy_drops", n_busy_drop, 0);
        chk("t3_fetch_pulses", n_fetch - f0, 9);
        chk("t3_frame_cnt", frame_cnt_o, 5);
        chk_rows("t3f2", q0 + 3);
        chk_rows("t3f3", q0 + 6);

        // VGA hand-off held for ten cycles
        start_frame();
        serve_fetch(2); serve_core(2);
        serve_fetch(2); serve_core(2);
        serve_fetch(2);
        vga_run_i = 1'b1;
        serve_core(2);
        chk("t4_done_state", state_o, 3);
        v0 = n_vga;
        tick();
        repeat (9) tick();
        vga_run_i = 1'b0;
        tick();
        chk("t4_vga_cycles", n_vga - v0, 10);
        chk("t4_state", state_o, 0);
        chk("t4_busy", busy_o, 0);
        chk("t4_frame_cnt", frame_cnt_o, 6);

        // Watchdog: sixteen CORE cycles with no done, then done on cycle 16
        start_frame();
        serve_fetch(2);
        c0 = n_corecyc;
        wait_state(5, 40);
        chk("t5_core_cycles", n_corecyc - c0, 16);
        chk("t5_err", err_timeout_o, 1);
        chk("t5_busy_err", busy_o, 0);
        start_frame();
        chk("t5_err_clr", err_timeout_o, 0);
        chk("t5_fetch_run", fetch_run_o, 1);
        chk("t5_fetch_row", fetch_row_o, 0);
        serve_fetch(2);
        repeat (15) tick();
        core_done_i = 1'b1; tick(); core_done_i = 1'b0;
        chk("t5_edge_state", state_o, 1);
        chk("t5_edge_err", err_timeout_o, 0);
        chk("t5_edge_row", fetch_row_o, 8);
        serve_fetch(2); serve_core(2);
        serve_fetch(2); serve_core(2);
        wait_state(0, 10);
        chk("t5_frame_cnt", frame_cnt_o, 7);

        // Abort together with core_done on stripe row 8
        start_frame();
        serve_fetch(2); serve_core(2);
        serve_fetch(2);
        chk("t6_row", fetch_row_o, 8);
        tick();
        d0 = n_done; f0 = n_fetch; c0 = n_core;
        abort_i = 1'b1; core_done_i = 1'b1;
        tick();
        abort_i = 1'b0; core_done_i = 1'b0;
        chk("t6_state", state_o, 0);
        chk("t6_row_clr", fetch_row_o, 0);
        repeat (3) tick();
        chk("t6_no_done", n_done - d0, 0);
        chk("t6_no_fetch", n_fetch - f0, 0);
        chk("t6_no_core", n_core - c0, 0);
        chk("t6_frame_cnt", frame_cnt_o, 7);

        // Asynchronous reset in the middle of FETCH
        start_frame();
        tick();
        chk("t7_in_fetch", state_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_state", state_o, 0);
        chk("t7_busy", busy_o, 0);
        chk("t7_fetch_run", fetch_run_o, 0);
        chk("t7_fetch_rows", fetch_rows_o, 0);
        chk("t7_frame_cnt", frame_cnt_o, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (3) tick();
        chk("t7_idle", state_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t expected=<200000", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/stripe_frame_controller.md
Name: stripe_frame_controller

Overview:
Top-level sequencer for the image pipeline. It walks a frame of IMG_ROW rows in stripes of STRIPE_ROWS rows. For each stripe it runs the fetch phase (BRAM -> memory controller -> buffer) and then the core phase (buffer -> core). After the last stripe it optionally hands the frame to VGA. It extends the earlier single-loop controller with stripe addressing, a partial last stripe, continuous mode, abort, a watchdog timeout and status outputs.

Parameters:
IMG_ROW, 540, frame height in rows (>=1)
STRIPE_ROWS, 8, rows per stripe (1..IMG_ROW)
ROW_W, 10, width of row index/count outputs; must satisfy 2^ROW_W > IMG_ROW
TIMEOUT_CYC, 1048576, max cycles allowed in FETCH or CORE; 0 disables the watchdog
TO_W, 21, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start_i  in  1  level; starts a frame when sampled high in IDLE or ERR
abort_i  in  1  level; forces IDLE, highest priority
mode_cont_i  in  1  1 = restart the next frame automatically after DONE/VGA
vga_run_i  in  1  level; VGA display requested
fetch_done_i  in  1  one-cycle pulse from memory controller: stripe fetched
core_done_i  in  1  one-cycle pulse from core: stripe processed
fetch_run_o  out  1  one-cycle pulse: start fetch of current stripe
fetch_row_o  out  ROW_W  first row of current stripe
fetch_rows_o  out  ROW_W  row count of current stripe (partial for last)
core_run_o  out  1  one-cycle pulse: start core on current stripe
vga_en_o  out  1  high while in VGA state
busy_o  out  1  high in FETCH, CORE, DONE, VGA
frame_done_o  out  1  one-cycle pulse on the completed frame
err_timeout_o  out  1  sticky watchdog error flag
state_o  out  3  current state encoding, for debug
frame_cnt_o  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, async): state=IDLE. All outputs 0, including fetch_row_o, frame_cnt_o, err_timeout_o and the watchdog count.
- State encoding: IDLE=0, FETCH=1, CORE=2, DONE=3, VGA=4, ERR=5. All outputs are registered.
- IDLE: if start_i=1 -> FETCH with row=0.
- FETCH:
  - fetch_run_o=1 in the first FETCH cycle only.
  - fetch_done_i is accepted in any FETCH cycle, including the first -> CORE.
- CORE:
  - core_run_o=1 in the first CORE cycle only.
  - On core_done_i: if row+STRIPE_ROWS >= IMG_ROW -> DONE; else row += STRIPE_ROWS -> FETCH.
- Stripe outputs: fetch_rows_o = min(STRIPE_ROWS, IMG_ROW-row). fetch_row_o and fetch_rows_o are stable from the fetch_run_o cycle until the next stripe's FETCH entry.
- DONE (one cycle): frame_done_o=1; frame_cnt_o += 1. Next state, in priority order:
  - vga_run_i=1 -> VGA
  - mode_cont_i=1 -> FETCH with row=0
  - otherwise -> IDLE
- VGA: vga_en_o=1 and busy_o=1. When vga_run_i=0: mode_cont_i=1 -> FETCH with row=0; else -> IDLE.
- Watchdog (TIMEOUT_CYC>0):
  - Counter clears on every entry to FETCH or CORE and increments each cycle spent there.
  - When count reaches TIMEOUT_CYC-1 with no done pulse that cycle -> ERR, err_timeout_o=1.
  - If a done pulse and the timeout occur in the same cycle, done wins.
- ERR: busy_o=0. start_i=1 clears err_timeout_o and goes to FETCH with row=0. Otherwise ERR holds.
- abort_i=1 in any state -> IDLE next cycle:
  - row clears to 0.
  - No fetch_run_o, core_run_o or frame_done_o pulse is emitted.
  - err_timeout_o is cleared.
  - abort_i outranks start_i and every done pulse in the same cycle.
- Done pulses are ignored outside their own state: fetch_done_i outside FETCH, core_done_i outside CORE.
- Done pulses held high longer than one cycle: fetch_done_i is counted once only, because the FSM leaves FETCH. The core_run_o pulse in the next state is unaffected.
- IMG_ROW divisible by STRIPE_ROWS: every stripe is full. STRIPE_ROWS=IMG_ROW: one stripe per frame.

Test Plan:
- IMG_ROW=20, STRIPE_ROWS=8; start_i pulse, fetch_done and core_done each 3 cycles after their run pulse -> fetch_row_o sequence 0,8,16 with fetch_rows_o 8,8,4. Exactly 3 fetch_run_o and 3 core_run_o pulses, one frame_done_o, frame_cnt_o=1, back to IDLE.
- fetch_done_i asserted in the same cycle as fetch_run_o, and stray core_done_i during FETCH -> CORE entered next cycle; stray pulse ignored; row sequence unchanged.
- mode_cont_i=1, vga_run_i=0, 3 frames -> after each DONE, fetch_run_o fires the next cycle with row 0; frame_cnt_o=3; busy_o never drops.
- vga_run_i=1 at DONE, held 10 cycles -> vga_en_o high 10 cycles, then IDLE (mode_cont_i=0) with busy_o=0.
- TIMEOUT_CYC=16, no core_done_i -> ERR after 16 CORE cycles, err_timeout_o=1. core_done_i exactly on cycle 16 -> no error. start_i in ERR -> flag cleared, fetch_run_o with row 0.
- abort_i during CORE on stripe row=8, simultaneous with core_done_i -> IDLE next cycle, row=0, no pulses. Async rst_n low mid-FETCH -> all outputs 0 immediately.
